// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder/subtractor, LSB first, one full-adder cell
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_MSB  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic             load;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             carry, msb_cin;
  logic             s, c;

  assign s       = a_sh[0] ^ b_sh[0] ^ carry;
  assign c       = (carry & (a_sh[0] ^ b_sh[0])) | (a_sh[0] & b_sh[0]);
  assign shifted = {s, acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      a_sh  <= a_in;
      b_sh  <= sub ? ~b_in : b_in;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc   <= shifted[WIDTH-1:1];
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= c;
      cnt   <= cnt + 1'b1;
      // the carry leaving bit WIDTH-2 is the carry entering the MSB
      if (cnt == PRE_MSB) msb_cin <= c;
      if (cnt == LAST_BIT) begin
        sum  <= shifted;
        cout <= c;
        ovf  <= msb_cin ^ c;
      end
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder/subtractor that streams operands LSB-first through a single full-adder cell and holds the carry in a flip-flop between bits. It is the sequential wrapper around the one-bit full-adder stage. It accepts parallel operands on a start/busy/done handshake, produces one sum bit per clock, and presents a registered parallel result with carry-out and signed-overflow flags. Typical users are area-constrained datapaths that can tolerate WIDTH-cycle latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on a rising edge of clk only while busy=0.
- sub  input  1  0 = a_in + b_in + cin; 1 = a_in - b_in (cin ignored). Sampled with start.
- a_in  input  WIDTH  operand A; sampled with start.
- b_in  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for add mode; sampled with start.
- busy  output  1  high while bits are being computed.
- done  output  1  one-cycle pulse; the result outputs are valid from this cycle on.
- sum  output  WIDTH  registered result; held until the next done.
- cout  output  1  carry out of the MSB. In subtract mode 1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE.** When start=1, capture the operands and enter RUN:
  - a_sh <= a_in;
  - b_sh <= sub ? ~b_in : b_in;
  - carry <= sub ? 1 : cin;
  - bit counter <= 0.
- **RUN.** On each edge:
  - s = a_sh[0]^b_sh[0]^carry;
  - c = (carry&(a_sh[0]^b_sh[0])) | (a_sh[0]&b_sh[0]);
  - shift s into the MSB of the internal accumulator; right-shift a_sh and b_sh;
  - carry <= c;
  - counter increments;
  - when counter = WIDTH-2, latch the current carry as msb_cin.
  - The edge that processes bit WIDTH-1 is the last RUN edge. On that edge:
    - sum <= {s, acc[WIDTH-1:1]};
    - cout <= c;
    - ovf <= msb_cin ^ c;
    - state goes to DONE.
- **DONE.** done=1 and busy=0 for exactly one cycle.
  - If start=1 in this cycle, it is accepted as in IDLE and the next state is RUN. This allows back-to-back operation with no bubble.
  - Otherwise the next state is IDLE.
- start while busy=1 is ignored. Operand or sub changes during RUN have no effect.
- sum, cout and ovf change only on the edge entering DONE. During RUN they keep the previous result.
- All arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Reset values (asynchronous, on rst_n low): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, all internal registers 0.
- Let E0 be the edge that samples start=1.
  - busy=1 after E0.
  - Bit i is computed at edge E(i+1).
  - At E(WIDTH): state=DONE, done=1, busy=0, and sum/cout/ovf are valid.
- Latency from the accepting edge to done is WIDTH clocks. For WIDTH=8 that is 8 clocks.
- Throughput is one operation per WIDTH+1 clocks when start is held high continuously.
- Reset asserted mid-RUN aborts the operation immediately. No done pulse is produced, outputs go to reset values, and the block is ready for a new start on the first edge after rst_n releases.
- start asserted in the same cycle that rst_n is released is accepted only if rst_n is high at that edge.

## Test plan
- WIDTH=8, add, A=0x3A, B=0x45, cin=0 -> done exactly 8 clocks after the accepting edge; sum=0x7F, cout=0, ovf=0. busy is high for 8 cycles and done is high for exactly 1.
- Add, A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then A=0x7F, B=0x01 -> sum=0x80, cout=0, ovf=1. Then A=0x00, B=0x00, cin=1 -> sum=0x01.
- Subtract, A=0x05, B=0x07 -> sum=0xFE, cout=0, ovf=0. Then A=0x80, B=0x01 -> sum=0x7F, cout=1, ovf=1.
- Start A=0x10+B=0x20, pulse start again at cycle 3 with A=0xAA, and change a_in/b_in during RUN -> the second start is ignored, result is sum=0x30, and sum holds its previous value until done.
- Hold start=1 across the DONE cycle with a new operand pair (0x01+0x02) -> the second op is accepted at the done edge, busy rises on the next cycle, and the second done arrives 9 clocks after the first with sum=0x03.
- Assert rst_n=0 at bit 4 of a run -> busy, done, sum, cout and ovf are 0 immediately and no done pulse follows. A new op (0x0F+0x01) after release gives sum=0x10.
- Exhaustive/random check at WIDTH=4 over all A, B, cin and sub combinations against a reference model of A±B.
